// File: rtl/prog_mem_pkg.sv
// Shared types and sizes for the program memory loader.
// Optional checksum checking is enabled by defining PROG_MEM_CHECKSUM_EN.
package prog_mem_pkg;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 4096;

  localparam logic [DATA_W-1:0] NOP_BYTE      = 8'h00;
  localparam logic [ADDR_W-1:0] LOAD_BASE_DEF = 12'h000;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    ERR     = 2'd3
  } pm_state_e;

endpackage

// File: rtl/prog_mem_ram.sv
// Simple dual-port RAM: loader write port, registered CPU read port.
// Read register clears synchronously so the CPU sees NOP_BYTE after reset.
module prog_mem_ram
  import prog_mem_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              rd_clr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Loader write port, no reset so contents survive rst.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // CPU read port with one cycle of latency.
  always_ff @(posedge clk_i) begin
    if (rd_clr_i) rdata_q <= NOP_BYTE;
    else          rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem.sv
// Program memory with a streaming loader that holds the CPU in reset.
// Define PROG_MEM_CHECKSUM_EN to treat the last byte as a checksum.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LOAD_BASE = LOAD_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_bus,
  output logic [DATA_W-1:0] data_bus,
  output logic              cpu_hold,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_err
);

  pm_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic              xfer;
  logic              we;
  logic [DATA_W-1:0] rdata;
`ifdef PROG_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  assign xfer = load_valid && (state_q == LOAD);

  // State, write pointer and checksum registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wptr_q  <= LOAD_BASE;
`ifdef PROG_MEM_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
`ifdef PROG_MEM_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Next-state logic: session open, byte accept, release or error.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
`ifdef PROG_MEM_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      RUN, ERR: begin
        if (load_start) begin
          state_d = LOAD;
          wptr_d  = LOAD_BASE;
`ifdef PROG_MEM_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LOAD: begin
        if (xfer) begin
`ifdef PROG_MEM_CHECKSUM_EN
          if (load_last) begin
            state_d = (load_data == csum_q) ? RELEASE : ERR;
          end else begin
            wptr_d = wptr_q + 1'b1;
            csum_d = csum_q + load_data;
          end
`else
          wptr_d = wptr_q + 1'b1;
          if (load_last) state_d = RELEASE;
`endif
        end
      end
      RELEASE: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
`ifdef PROG_MEM_CHECKSUM_EN
    we       = xfer && !load_last;
    load_err = (state_q == ERR);
`else
    we       = xfer;
    load_err = 1'b0;
`endif
    cpu_hold   = (state_q != RUN);
    load_ready = (state_q == LOAD);
    data_bus   = (state_q == RUN) ? rdata : NOP_BYTE;
  end

  prog_mem_ram u_ram (
    .clk_i    (clk),
    .we_i     (we),
    .waddr_i  (wptr_q),
    .wdata_i  (load_data),
    .raddr_i  (addr_bus),
    .rd_clr_i (rst),
    .rdata_o  (rdata)
  );

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: loads, wrap, stalls, reset abort.
// Checksum sessions run when PROG_MEM_CHECKSUM_EN is defined.
module tb_prog_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr_bus;
  logic [7:0]  data_lo, data_hi;
  logic        hold_lo, hold_hi;
  logic        ready_lo, ready_hi;
  logic        err_lo, err_hi;
  logic        load_start, load_valid, load_last;
  logic [7:0]  load_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prog_mem #(.LOAD_BASE(12'h000)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .addr_bus   (addr_bus),
    .data_bus   (data_lo),
    .cpu_hold   (hold_lo),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (ready_lo),
    .load_err   (err_lo)
  );

  prog_mem #(.LOAD_BASE(12'hFFE)) u_dut_hi (
    .clk        (clk),
    .rst        (rst),
    .addr_bus   (addr_bus),
    .data_bus   (data_hi),
    .cpu_hold   (hold_hi),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (ready_hi),
    .load_err   (err_hi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 8'hEE;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a,
                    input logic [7:0] e);
    addr_bus = a;
    tick();
    check(tag, {4'h0, data_lo}, {4'h0, e});
  endtask

  task automatic rdh(input string tag, input logic [11:0] a,
                     input logic [7:0] e);
    addr_bus = a;
    tick();
    check(tag, {4'h0, data_hi}, {4'h0, e});
  endtask

  initial begin
    rst        = 1'b1;
    addr_bus   = '0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 8'h00;
    tick();
    tick();
    check("rst_data", {4'h0, data_lo}, 12'h000);
    check("rst_hold", {11'h0, hold_lo}, 12'h000);
    check("rst_ready", {11'h0, ready_lo}, 12'h000);
    check("rst_err", {11'h0, err_lo}, 12'h000);
    rst = 1'b0;
    tick();

`ifdef PROG_MEM_CHECKSUM_EN
    start();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    send(8'h0A, 1'b1);
    tick();
    start();
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    send(8'h60, 1'b1);
    check("cs_ok_hold", {11'h0, hold_lo}, 12'h001);
    check("cs_ok_err", {11'h0, err_lo}, 12'h000);
    tick();
    check("cs_ok_run", {11'h0, hold_lo}, 12'h000);
    rd("cs_m0", 12'h000, 8'h10);
    rd("cs_m1", 12'h001, 8'h20);
    rd("cs_m2", 12'h002, 8'h30);
    rd("cs_m3_kept", 12'h003, 8'h04);
    start();
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    send(8'h61, 1'b1);
    check("cs_bad_err", {11'h0, err_lo}, 12'h001);
    check("cs_bad_hold", {11'h0, hold_lo}, 12'h001);
    tick();
    tick();
    check("cs_err_sticky", {11'h0, err_lo}, 12'h001);
    check("cs_err_hold", {11'h0, hold_lo}, 12'h001);
    check("cs_err_data", {4'h0, data_lo}, 12'h000);
    check("cs_err_ready", {11'h0, ready_lo}, 12'h000);
    start();
    check("cs_restart_err", {11'h0, err_lo}, 12'h000);
    check("cs_restart_rdy", {11'h0, ready_lo}, 12'h001);
`else
    start();
    check("s1_hold", {11'h0, hold_lo}, 12'h001);
    check("s1_ready", {11'h0, ready_lo}, 12'h001);
    check("s1_data_nop", {4'h0, data_lo}, 12'h000);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    check("s1_rel_hold", {11'h0, hold_lo}, 12'h001);
    check("s1_rel_ready", {11'h0, ready_lo}, 12'h000);
    tick();
    check("s1_run_hold", {11'h0, hold_lo}, 12'h000);
    rd("s1_m1", 12'h001, 8'hBB);
    rd("s1_m0", 12'h000, 8'hAA);
    rd("s1_m2", 12'h002, 8'hCC);

    load_valid = 1'b1;
    load_last  = 1'b1;
    load_data  = 8'hEE;
    tick();
    check("run_ready", {11'h0, ready_lo}, 12'h000);
    load_valid = 1'b0;
    load_last  = 1'b0;
    rd("run_nowrite", 12'h000, 8'hAA);

    start();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    tick();
    rdh("wrap_ffe", 12'hFFE, 8'h01);
    rdh("wrap_fff", 12'hFFF, 8'h02);
    rdh("wrap_000", 12'h000, 8'h03);
    rdh("wrap_001", 12'h001, 8'h04);
    rd("lo_m3", 12'h003, 8'h04);

    start();
    load_valid = 1'b1;
    load_data  = 8'h11;
    tick();
    load_valid = 1'b0;
    load_data  = 8'hEE;
    tick();
    load_valid = 1'b1;
    load_data  = 8'h22;
    tick();
    load_valid = 1'b0;
    load_data  = 8'hEE;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("stall_ready", {11'h0, ready_lo}, 12'h001);
    load_valid = 1'b1;
    load_data  = 8'h33;
    tick();
    load_valid = 1'b0;
    load_data  = 8'hEE;
    tick();
    send(8'h44, 1'b1);
    check("stall_rel", {11'h0, hold_lo}, 12'h001);
    tick();
    rd("stall_m0", 12'h000, 8'h11);
    rd("stall_m1", 12'h001, 8'h22);
    rd("stall_m2", 12'h002, 8'h33);
    rd("stall_m3", 12'h003, 8'h44);

    start();
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_hold", {11'h0, hold_lo}, 12'h000);
    check("abort_ready", {11'h0, ready_lo}, 12'h000);
    check("abort_data", {4'h0, data_lo}, 12'h000);
    check("abort_err", {11'h0, err_lo}, 12'h000);
    rd("abort_m0", 12'h000, 8'h55);
    rd("abort_m1", 12'h001, 8'h66);
    rd("abort_m2", 12'h002, 8'h33);
    rd("abort_m3", 12'h003, 8'h44);

    start();
    send(8'h77, 1'b1);
    check("zero_rel", {11'h0, ready_lo}, 12'h000);
    tick();
    rd("zero_m0", 12'h000, 8'h77);
    rd("zero_m1", 12'h001, 8'h66);
    check("zero_err", {11'h0, err_lo}, 12'h000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
